seven_segment_decoder: RTL and testbench

SEVEN_SEGMENT_DECODER -- requirements
Module: seven_segment_decoder

---
 rtl/seven_segment_pkg.sv | 25 ++
 rtl/seven_segment_if.sv | 21 ++
 rtl/seven_segment_rom.sv | 32 +++
 rtl/seven_segment_decoder.sv | 56 +++++
 tb/tb_seven_segment_decoder.sv | 131 +++++++++++++
 5 files changed

// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment display path: segment vector type,
// the sixteen hex glyphs in {a,b,c,d,e,f,g} order, and the blank glyph.
package seven_segment_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b0011111;
  localparam seg_t SEG_C     = 7'b1001110;
  localparam seg_t SEG_D     = 7'b0111101;
  localparam seg_t SEG_E     = 7'b1001111;
  localparam seg_t SEG_F     = 7'b1000111;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seven_segment_if.sv
// Display bus: digit/dot/blank request toward the decoder, registered
// segment and decimal-point drives back out.
interface seven_segment_if;

  logic [3:0] in;
  logic       dot_in;
  logic       blank;
  logic       a, b, c, d, e, f, g;
  logic       dot;

  modport master (
    output in, dot_in, blank,
    input  a, b, c, d, e, f, g, dot
  );

  modport slave (
    input  in, dot_in, blank,
    output a, b, c, d, e, f, g, dot
  );

endinterface

// File: rtl/seven_segment_rom.sv
// Combinational hex-digit to segment-pattern lookup (active-high glyphs).
module seven_segment_rom
  import seven_segment_pkg::*;
(
  input  logic [3:0] in,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (in)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// Seven-segment decoder: glyph lookup, blank/dot muxing, display polarity and
// a single output register (one cycle latency, async reset to dark display).
module seven_segment_decoder
  import seven_segment_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
)(
  input  logic            clk,
  input  logic            rst,
  seven_segment_if.slave  bus
);

  // Dark level of every drive, as seen on the pins.
  localparam logic [7:0] DRV_DARK = ACTIVE_LOW ? 8'hFF : 8'h00;

  function automatic logic [7:0] apply_polarity(input logic [7:0] lit);
    return ACTIVE_LOW ? ~lit : lit;
  endfunction

  function automatic logic [7:0] apply_blank(input seg_t seg, input logic dp,
                                             input logic blank);
    return blank ? {SEG_BLANK, 1'b0} : {seg, dp};
  endfunction

  seg_t       seg_p0;
  logic [7:0] lit_p0;
  logic [7:0] drv_p0;
  logic [7:0] drv_p1;

  // Stage p0: decode, blank override, polarity
  seven_segment_rom u_rom (
    .in  (bus.in),
    .seg (seg_p0)
  );

  always_comb begin
    lit_p0 = apply_blank(seg_p0, bus.dot_in, bus.blank);
    drv_p0 = apply_polarity(lit_p0);
  end

  // Stage p1: output register holding post-polarity drives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drv_p1 <= DRV_DARK;
    else     drv_p1 <= drv_p0;
  end

  assign bus.a   = drv_p1[7];
  assign bus.b   = drv_p1[6];
  assign bus.c   = drv_p1[5];
  assign bus.d   = drv_p1[4];
  assign bus.e   = drv_p1[3];
  assign bus.f   = drv_p1[2];
  assign bus.g   = drv_p1[1];
  assign bus.dot = drv_p1[0];

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Bench for seven_segment_decoder: both polarities driven in lockstep,
// expectations queued at each edge and checked by an independent monitor.
module tb_seven_segment_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  seven_segment_if bus0 ();
  seven_segment_if bus1 ();

  seven_segment_decoder #(.ACTIVE_LOW(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  seven_segment_decoder #(.ACTIVE_LOW(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  // Glyphs in {a..g} order for hex 0..F, as a lit-segment table.
  logic [6:0] glyph [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  function automatic logic [7:0] model(input logic [3:0] digit, input logic dp,
                                       input logic bl, input bit al);
    logic [7:0] lit;
    lit = bl ? 8'h00 : {glyph[digit], dp};
    return al ? ~lit : lit;
  endfunction

  function automatic logic [7:0] pins0();
    return {bus0.a, bus0.b, bus0.c, bus0.d, bus0.e, bus0.f, bus0.g, bus0.dot};
  endfunction

  function automatic logic [7:0] pins1();
    return {bus1.a, bus1.b, bus1.c, bus1.d, bus1.e, bus1.f, bus1.g, bus1.dot};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %b required %b at %0t", name, got, want, $time);
    end
  endtask

  // Drive between edges, then queue what the next edge must produce.
  task automatic apply(input logic [3:0] digit, input logic dp, input logic bl);
    @(negedge clk);
    bus0.in = digit; bus0.dot_in = dp; bus0.blank = bl;
    bus1.in = digit; bus1.dot_in = dp; bus1.blank = bl;
    @(posedge clk);
    q0.push_back(model(digit, dp, bl, 1'b0));
    q1.push_back(model(digit, dp, bl, 1'b1));
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && q0.size() > 0) begin
      check("pins_al0", pins0(), q0.pop_front());
      check("pins_al1", pins1(), q1.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.in = 4'h8; bus0.dot_in = 1'b1; bus0.blank = 1'b0;
    bus1.in = 4'h8; bus1.dot_in = 1'b1; bus1.blank = 1'b0;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    check("reset_al0", pins0(), 8'h00);
    check("reset_al1", pins1(), 8'hFF);
    @(negedge clk);
    check("reset_hold_al0", pins0(), 8'h00);
    check("reset_hold_al1", pins1(), 8'hFF);
    rst = 1'b0;

    // Sweep all digits, dot off
    for (int i = 0; i < 16; i++) apply(4'(i), 1'b0, 1'b0);

    // Dot toggling on a steady digit
    for (int i = 0; i < 6; i++) apply(4'h3, 1'(i % 2), 1'b0);

    // Blank priority and release
    apply(4'h8, 1'b1, 1'b1);
    apply(4'h8, 1'b1, 1'b1);
    apply(4'h8, 1'b1, 1'b0);

    // Polarity case: digit 1 with dot off
    apply(4'h1, 1'b0, 1'b0);

    // Mid-operation reset while displaying 5
    apply(4'h5, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_al0", pins0(), 8'h00);
    check("midrst_al1", pins1(), 8'hFF);
    @(posedge clk); #1;
    check("midrst_edge_al0", pins0(), 8'h00);
    check("midrst_edge_al1", pins1(), 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    apply(4'h5, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 200; i++)
      apply(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0));

    @(posedge clk); #2;
    check("queue_drained", 8'(q0.size() + q1.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
